// File: rtl/uart_rx_fsm_if.sv
// uart_rx_fsm_if: serial line, checker handshakes and frame result strobes of the UART RX sequencer.
interface uart_rx_fsm_if #(parameter int PRESC_W = 6);
  logic               RX_IN;
  logic [PRESC_W-1:0] Prescale;
  logic               PAR_EN;
  logic               strt_glitch;
  logic               par_err;
  logic               stp_err;
  logic               samp_en;
  logic               deser_en;
  logic               strt_chk_en;
  logic               par_chk_en;
  logic               stp_chk_en;
  logic               data_valid;
  logic               frame_err;
  logic               parity_err;
  modport master (
    output RX_IN, Prescale, PAR_EN, strt_glitch, par_err, stp_err,
    input  samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid, frame_err, parity_err
  );
  modport slave (
    input  RX_IN, Prescale, PAR_EN, strt_glitch, par_err, stp_err,
    output samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid, frame_err, parity_err
  );
endinterface

// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm: UART RX sequencer timing each bit with an oversampling edge counter,
// strobing sampler/deserializer/checkers and emitting one result pulse per frame.
module uart_rx_fsm #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6
) (
  input logic           CLK,
  input logic           RST,
  uart_rx_fsm_if.slave  bus
);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t             state_q, state_d;
  logic [PRESC_W-1:0] edge_q, edge_d, presc_q, presc_d, half, last;
  logic [BW-1:0]      bit_q, bit_d;
  logic               glitch_q, glitch_d, perr_q, perr_d, serr_q, serr_d;
  logic               dv_q, dv_d, fe_q, fe_d, pe_q, pe_d;
  logic               active, bit_end, chk_edge, res_edge;
  assign half     = presc_q >> 1;
  assign last     = presc_q - PRESC_W'(1);
  assign active   = state_q != IDLE;
  assign bit_end  = active && edge_q == last;
  assign chk_edge = active && edge_q == half + PRESC_W'(2);
  assign res_edge = active && edge_q == half + PRESC_W'(3);
  assign bus.samp_en     = active && (edge_q == half - PRESC_W'(1) || edge_q == half || edge_q == half + PRESC_W'(1));
  assign bus.strt_chk_en = chk_edge && state_q == START;
  assign bus.deser_en    = chk_edge && state_q == DATA;
  assign bus.par_chk_en  = chk_edge && state_q == PARITY;
  assign bus.stp_chk_en  = chk_edge && state_q == STOP;
  assign bus.data_valid  = dv_q;
  assign bus.frame_err   = fe_q;
  assign bus.parity_err  = pe_q;
  always_comb begin
    state_d  = state_q;
    edge_d   = edge_q;
    presc_d  = presc_q;
    bit_d    = bit_q;
    glitch_d = glitch_q | (res_edge && state_q == START && bus.strt_glitch);
    perr_d   = perr_q | (res_edge && state_q == PARITY && bus.par_err);
    serr_d   = serr_q | (res_edge && state_q == STOP && bus.stp_err);
    dv_d     = 1'b0;
    fe_d     = 1'b0;
    pe_d     = 1'b0;
    if (!active) begin
      glitch_d = 1'b0;
      perr_d   = 1'b0;
      serr_d   = 1'b0;
      edge_d   = bus.RX_IN ? '0 : PRESC_W'(1);
      state_d  = bus.RX_IN ? IDLE : START;
      presc_d  = bus.RX_IN ? presc_q : bus.Prescale;
    end else begin
      edge_d = bit_end ? '0 : edge_q + PRESC_W'(1);
      // a checker result arriving on the bit-end cycle is folded in through the _d latches
      if (bit_end) begin
        case (state_q)
          START: begin
            state_d = glitch_d ? IDLE : DATA;
            bit_d   = '0;
          end
          DATA: begin
            bit_d   = bit_q + BW'(1);
            state_d = bit_q != LAST_BIT ? DATA : bus.PAR_EN ? PARITY : STOP;
          end
          PARITY: state_d = STOP;
          default: begin
            state_d = IDLE;
            dv_d    = !(perr_d || serr_d);
            fe_d    = serr_d;
            pe_d    = perr_d;
          end
        endcase
      end
    end
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      edge_q   <= '0;
      presc_q  <= '0;
      bit_q    <= '0;
      glitch_q <= 1'b0;
      perr_q   <= 1'b0;
      serr_q   <= 1'b0;
      dv_q     <= 1'b0;
      fe_q     <= 1'b0;
      pe_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      edge_q   <= edge_d;
      presc_q  <= presc_d;
      bit_q    <= bit_d;
      glitch_q <= glitch_d;
      perr_q   <= perr_d;
      serr_q   <= serr_d;
      dv_q     <= dv_d;
      fe_q     <= fe_d;
      pe_q     <= pe_d;
    end
  end
endmodule

// File: tb/tb_uart_rx_fsm.sv
// tb_uart_rx_fsm: directed and randomized frames against a positional model of
// where every strobe and result pulse must fall within a frame.
module tb_uart_rx_fsm;
  localparam int DW = 8;
  localparam int PW = 6;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic rst_drv = 1'b0;
  int checks = 0;
  int failures = 0;
  logic [2:0] pend = 3'b000;
  int n_deser = 0;
  int n_dv = 0;
  int n_err = 0;
  uart_rx_fsm_if #(.PRESC_W(PW)) bus ();
  uart_rx_fsm #(.DATA_WIDTH(DW), .PRESC_W(PW)) dut (.CLK(CLK), .RST(RST), .bus(bus.slave));
  always #5 CLK = ~CLK;
  function automatic logic [7:0] obs_w();
    return {bus.samp_en, bus.deser_en, bus.strt_chk_en, bus.par_chk_en,
            bus.stp_chk_en, bus.data_valid, bus.frame_err, bus.parity_err};
  endfunction
  function automatic int rand_p();
    int r;
    r = $urandom_range(0, 2);
    return r == 0 ? 8 : r == 1 ? 16 : 32;
  endfunction
  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic cycle_io(input logic rx, input int p, input logic pen, input logic sg,
                          input logic pe, input logic se, output logic [7:0] w);
    @(posedge CLK);
    #1;
    RST = rst_drv;
    bus.RX_IN = rx;
    bus.Prescale = PW'(p);
    bus.PAR_EN = pen;
    bus.strt_glitch = sg;
    bus.par_err = pe;
    bus.stp_err = se;
    #1;
    w = obs_w();
    n_deser += int'(w[6]);
    n_dv += int'(w[2]);
    n_err += int'(w[1] | w[0]);
  endtask
  task automatic run_idle(input int n, input string tag);
    logic [7:0] w, expw;
    int mis;
    mis = 0;
    for (int t = 0; t < n; t++) begin
      expw = (t == 0) ? {5'b0, pend} : 8'h00;
      cycle_io(1'b1, rand_p(), 1'($urandom), 1'b0, 1'b0, 1'b0, w);
      mis += int'(w != expw);
    end
    pend = 3'b000;
    check({tag, "_idle_mismatch_cycles"}, mis, 0);
  endtask
  task automatic run_frame(input int p, input logic pen, input logic [7:0] data, input logic stopv,
                           input logic glitch, input logic perr, input logic serr,
                           input int rst_at, input string tag);
    int h, nb, len, k, e;
    logic [7:0] w, expw;
    logic rx, sg, pq, sq;
    int mis [8];
    h = p / 2;
    nb = glitch ? 1 : (pen ? DW + 3 : DW + 2);
    len = nb * p;
    sg = 1'b0;
    pq = 1'b0;
    sq = 1'b0;
    foreach (mis[s]) mis[s] = 0;
    for (int t = 0; t < len; t++) begin
      k = t / p;
      e = t % p;
      rx = glitch ? (t >= 3) : k == 0 ? 1'b0 : k <= DW ? data[k-1] : (pen && k == DW + 1) ? ^data : stopv;
      expw = (t == 0) ? {5'b0, pend} : 8'h00;
      expw[7] = (e >= h - 1 && e <= h + 1);
      if (e == h + 2) begin
        if (k == 0) expw[5] = 1'b1;
        else if (k <= DW) expw[6] = 1'b1;
        else if (pen && k == DW + 1) expw[4] = 1'b1;
        else expw[3] = 1'b1;
      end
      if (t == rst_at) begin
        rst_drv = 1'b0;
        expw = 8'h00;
      end
      cycle_io(rx, (t == 0) ? p : rand_p(), (t == (DW + 1) * p - 1) ? pen : 1'($urandom), sg, pq, sq, w);
      for (int s = 0; s < 8; s++) mis[s] += int'(w[s] != expw[s]);
      sg = w[5] & glitch;
      pq = w[4] & perr;
      sq = w[3] & serr;
      if (t == rst_at) break;
    end
    pend = (glitch || rst_at >= 0) ? 3'b000 : {!(serr || (pen && perr)), serr, pen && perr};
    for (int s = 0; s < 8; s++) check($sformatf("%s_sig%0d_mismatch_cycles", tag, s), mis[s], 0);
  endtask
  initial begin
    int d0, v0, e0;
    logic [7:0] w;
    bus.RX_IN = 1'b1;
    bus.Prescale = PW'(8);
    bus.PAR_EN = 1'b0;
    bus.strt_glitch = 1'b0;
    bus.par_err = 1'b0;
    bus.stp_err = 1'b0;
    #1 RST = 1'b0;
    repeat (3) @(posedge CLK);
    #2;
    check("reset_outputs", int'(obs_w()), 0);
    rst_drv = 1'b1;
    run_idle(3, "post_reset");
    d0 = n_deser; v0 = n_dv; e0 = n_err;
    run_frame(8, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, -1, "t1_p8_a5");
    run_idle(4, "t1");
    check("t1_deser_count", n_deser - d0, 8);
    check("t1_dv_count", n_dv - v0, 1);
    check("t1_err_count", n_err - e0, 0);
    v0 = n_dv; e0 = n_err;
    run_frame(16, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, -1, "t2_par_ok");
    run_idle(2, "t2a");
    run_frame(16, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, -1, "t2_par_err");
    run_idle(2, "t2b");
    check("t2_dv_count", n_dv - v0, 1);
    check("t2_err_count", n_err - e0, 1);
    d0 = n_deser; v0 = n_dv; e0 = n_err;
    run_frame(16, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, -1, "t3_glitch");
    run_idle(40, "t3");
    check("t3_deser_count", n_deser - d0, 0);
    check("t3_result_count", (n_dv - v0) + (n_err - e0), 0);
    v0 = n_dv;
    run_frame(8, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, -1, "t4_stop_err");
    run_frame(8, 1'b0, 8'h81, 1'b1, 1'b0, 1'b0, 1'b0, -1, "t4_good");
    run_idle(3, "t4");
    check("t4_dv_count", n_dv - v0, 1);
    run_frame(8, 1'b0, 8'hC3, 1'b1, 1'b0, 1'b0, 1'b0, 5 * 8 + 2, "t5_reset");
    run_idle(3, "t5_in_reset");
    rst_drv = 1'b1;
    run_idle(2, "t5_release");
    v0 = n_dv;
    run_frame(8, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, -1, "t5_ff");
    run_idle(2, "t5");
    check("t5_dv_count", n_dv - v0, 1);
    d0 = n_deser; v0 = n_dv;
    run_frame(32, 1'b0, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0, -1, "t6_55");
    run_frame(32, 1'b0, 8'hAA, 1'b1, 1'b0, 1'b0, 1'b0, -1, "t6_aa");
    run_idle(3, "t6");
    check("t6_deser_count", n_deser - d0, 16);
    check("t6_dv_count", n_dv - v0, 2);
    for (int i = 0; i < 20; i++) begin
      logic gl;
      gl = ($urandom_range(0, 7) == 0);
      run_frame(rand_p(), 1'($urandom), 8'($urandom), 1'($urandom), gl,
                1'($urandom), 1'($urandom_range(0, 3) == 0), -1, $sformatf("rnd%0d", i));
      if ($urandom_range(0, 1) == 1) run_idle($urandom_range(1, 4), $sformatf("rnd%0d", i));
    end
    run_idle(2, "final");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
